// File: rtl/mem_stage_port_pkg.sv
// Shared definitions for the MEM-stage data port: access-size codes, FSM states
// and the alignment rule used to reject misaligned accesses.
package mem_stage_port_pkg;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reserved size code 2'b11 behaves as a word, so it falls into the default arm.
  function automatic logic is_misaligned(input logic [1:0] datatype, input logic [1:0] offset);
    case (datatype)
      DT_HALF: return offset[0];
      DT_BYTE: return 1'b0;
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational little-endian lane steering: byte enables and store replication
// on the way out, byte/half extraction with sign or zero extension on the way in.
module mem_lane_align
  import mem_stage_port_pkg::*;
(
  input  logic [1:0]  datatype,
  input  logic [1:0]  offset,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] word_in,
  output logic [3:0]  be,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  lanes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lanes[gi] = word_in[8*gi +: 8];
  end

  always_comb begin
    byte_sel   = lanes[offset];
    half_sel   = offset[1] ? word_in[31:16] : word_in[15:0];
    be         = 4'b1111;
    store_word = store_data;
    load_data  = word_in;
    case (datatype)
      DT_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{~load_unsigned & half_sel[15]}}, half_sel};
      end
      DT_BYTE: begin
        be         = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_port.sv
// MEM-stage data-memory port: latches one access in IDLE, holds the request on the
// bus until mem_ack or timeout, then presents formatted ReadData for one DONE cycle.
module mem_stage_port
  import mem_stage_port_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Datatype,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  output logic                  MisalignFault,
  output logic                  BusError,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  state_t                state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [3:0]            be_reg, be_next;
  logic [31:0]           wdata_reg, wdata_next;
  logic [1:0]            dt_reg, dt_next;
  logic [1:0]            off_reg, off_next;
  logic                  uns_reg, uns_next;
  logic [31:0]           rdata_q_reg, rdata_q_next;
  logic                  berr_reg, berr_next;

  logic        access;
  logic        misaligned;
  logic        in_idle;
  logic [1:0]  align_dt;
  logic [1:0]  align_off;
  logic        align_uns;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_load;

  assign access     = MemRead | MemWrite;
  assign misaligned = is_misaligned(Datatype, Address[1:0]);
  assign in_idle    = (state_reg == S_IDLE);

  // One aligner serves both directions: live inputs for store lanes in IDLE,
  // latched size/offset for load formatting while waiting on the ack.
  assign align_dt  = in_idle ? Datatype        : dt_reg;
  assign align_off = in_idle ? Address[1:0]    : off_reg;
  assign align_uns = in_idle ? LoadUnsigned    : uns_reg;

  mem_lane_align u_align (
    .datatype      (align_dt),
    .offset        (align_off),
    .load_unsigned (align_uns),
    .store_data    (WriteData),
    .word_in       (mem_rdata),
    .be            (align_be),
    .store_word    (align_wdata),
    .load_data     (align_load)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    be_next       = be_reg;
    wdata_next    = wdata_reg;
    dt_next       = dt_reg;
    off_next      = off_reg;
    uns_next      = uns_reg;
    rdata_q_next  = rdata_q_reg;
    berr_next     = berr_reg;
    Stall         = 1'b0;
    MisalignFault = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (access && misaligned) begin
          MisalignFault = 1'b1;
        end else if (access) begin
          Stall      = 1'b1;
          we_next    = MemWrite;
          addr_next  = {Address[ADDR_WIDTH-1:2], 2'b00};
          be_next    = align_be;
          wdata_next = align_wdata;
          dt_next    = Datatype;
          off_next   = Address[1:0];
          uns_next   = LoadUnsigned;
          cnt_next   = 8'd0;
          berr_next  = 1'b0;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        Stall = 1'b1;
        if (mem_ack) begin
          rdata_q_next = we_reg ? 32'd0 : align_load;
          state_next   = S_DONE;
        end else if (cnt_reg == 8'(TIMEOUT_CYCLES - 1)) begin
          berr_next    = 1'b1;
          rdata_q_next = 32'd0;
          state_next   = S_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      S_DONE: begin
        berr_next  = 1'b0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      be_reg      <= 4'd0;
      wdata_reg   <= 32'd0;
      dt_reg      <= DT_WORD;
      off_reg     <= 2'd0;
      uns_reg     <= 1'b0;
      rdata_q_reg <= 32'd0;
      berr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      be_reg      <= be_next;
      wdata_reg   <= wdata_next;
      dt_reg      <= dt_next;
      off_reg     <= off_next;
      uns_reg     <= uns_next;
      rdata_q_reg <= rdata_q_next;
      berr_reg    <= berr_next;
    end
  end

  assign mem_req   = (state_reg == S_REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_be    = be_reg;
  assign mem_wdata = wdata_reg;
  assign ReadData  = (state_reg == S_DONE) ? rdata_q_reg : 32'd0;
  assign BusError  = (state_reg == S_DONE) & berr_reg;

endmodule

// File: doc/mem_stage_port.md
Name: mem_stage_port

Overview:
Multi-cycle data-memory port that sits directly downstream of the EX/MEM pipeline register. It consumes the MEM-stage address, store data, MemRead, MemWrite and Datatype fields, and drives a request/acknowledge backing-memory bus. It performs byte-lane steering and load extension, then returns ReadData to the MEM/WB register. While a memory access is in flight it asserts Stall so the pipeline holds.

Parameters:
TIMEOUT_CYCLES, 16, maximum number of cycles in REQ without mem_ack before the access aborts with BusError (range 2..255).
ADDR_WIDTH, 32, width of the byte address presented by the pipeline and of mem_addr.

Ports:
Clk  input  1  pipeline clock; all state updates on the rising edge
Rst  input  1  synchronous, active-high reset
MemRead  input  1  MEM-stage load request
MemWrite  input  1  MEM-stage store request
Datatype  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word)
LoadUnsigned  input  1  1 selects zero-extension for lbu/lhu; 0 selects sign-extension
Address  input  ADDR_WIDTH  byte address (ALU result)
WriteData  input  32  store data (rt)
ReadData  output  32  formatted load data; valid in DONE, 0 otherwise
Stall  output  1  holds the PC and all pipeline registers
MisalignFault  output  1  one-cycle pulse for a misaligned access
BusError  output  1  one-cycle pulse in DONE after a timeout
mem_req  output  1  backing-memory request
mem_we  output  1  1 = write
mem_addr  output  ADDR_WIDTH  word-aligned address ({Address[ADDR_WIDTH-1:2], 2'b00})
mem_be  output  4  byte enables; bit i covers wdata[8i+7:8i]
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  completion strobe; honoured only in REQ
mem_rdata  input  32  read word; valid with mem_ack

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high (Rst). On reset, state = IDLE, timeout counter = 0, and all registered request fields and rdata_q are cleared. Reset values of the outputs: mem_req 0, mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, ReadData 0, BusError 0. Stall and MisalignFault are combinational from IDLE-state decode; they follow the inputs under Rst.
- Byte order is little-endian: byte offset 0 maps to bits 7:0.
- Access decode: access = MemRead | MemWrite. If both are high, the operation is a store and ReadData stays 0.
- Misalignment: a halfword with Address[0]=1, or a word with Address[1:0]!=0.
- Store lanes:
  - Word: be = 1111; wdata = WriteData.
  - Halfword: be = 0011 if Address[1]=0, else 1100; wdata = {2{WriteData[15:0]}}.
  - Byte: be = 0001 << Address[1:0]; wdata = {4{WriteData[7:0]}}.
- Load formatting: select the addressed byte or half from mem_rdata, then sign- or zero-extend it per LoadUnsigned.
- IDLE state:
  - Aligned access: Stall = 1 combinationally in this same cycle. Latch we, addr, be and wdata, clear the counter, go to REQ.
  - Misaligned access: MisalignFault = 1 and Stall = 0; no request is issued; stay in IDLE.
  - mem_ack is ignored.
- REQ state:
  - mem_req = 1, with the latched fields driven on the bus; Stall = 1.
  - On mem_ack: rdata_q <= formatted load (or 0 for a store), go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES-1 without an ack: set the BusError flag, rdata_q <= 0, go to DONE.
- DONE state:
  - mem_req = 0, Stall = 0, ReadData = rdata_q, BusError shown if flagged.
  - The pipeline advances at the end of this cycle. Go to IDLE, clear the flag; the same instruction is never re-issued.
- Latency: access seen at cycle t, ack k cycles after REQ entry (k >= 0). Stall is high for cycles t..t+k+1, DONE is at t+k+2, so the minimum stall is 2 cycles.
- Reset mid-operation: mem_req drops at the edge where Rst is sampled. A late mem_ack after reset is ignored.
- Inputs may change while Stall = 1; only the values latched in IDLE are used.

Decomposition:
- Shared package: Datatype constants DT_WORD=2'b00, DT_HALF=2'b01, DT_BYTE=2'b10; state encoding S_IDLE, S_REQ, S_DONE.
- One combinational sub-module, mem_lane_align: byte-enable generation, store replication, and load extraction/extension. It is reused by the instruction-side port later.

Test Plan:
- lw at 0x100, mem_rdata=0xDEADBEEF, ack on the 1st REQ cycle -> Stall high for 2 cycles, ReadData=0xDEADBEEF in DONE, mem_addr=0x100.
- lb at 0x103, LoadUnsigned=0, mem_rdata=0x80112233 -> ReadData=0xFFFFFF80; repeat with LoadUnsigned=1 -> 0x00000080.
- sh at 0x202, WriteData=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, ReadData=0.
- lw at 0x101 -> MisalignFault pulses 1 cycle, mem_req never rises, Stall stays 0.
- lw with no ack, TIMEOUT_CYCLES=16 -> mem_req high for exactly 16 cycles, then DONE with BusError=1 and ReadData=0, then IDLE.
- Rst asserted on the 3rd REQ cycle, ack on the next cycle -> state IDLE, mem_req=0, ack ignored, ReadData=0.
